// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit.
// Op encodings, FSM states and default datapath width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MFHI  = 3'd4,
    MDU_MFLO  = 3'd5,
    MDU_MTHI  = 3'd6,
    MDU_MTLO  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative datapath: shift-add multiply and restoring divide,
// one bit per step, on magnitudes only.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   opnd;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] acc_nxt;

  // acc = {upper, lower}: product/remainder above, multiplier/quotient below
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
          + (acc[0] ? {1'b0, opnd} : '0);
    shl   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial = shl - {1'b0, opnd};
    if (is_div) begin
      if (trial[WIDTH])
        acc_nxt = {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= {{WIDTH{1'b0}}, a_mag};
      opnd <= b_mag;
    end else if (step) begin
      acc  <= acc_nxt;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// MDU control: FSM, sign handling, HI/LO registers and stall
// generation for the EX stage.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  mdu_state_e state;
  mdu_op_e    op_e;

  logic [CNTW-1:0]    cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic               signed_op;
  logic               sa;
  logic               sb;
  logic               load;
  logic               step;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op_e      = mdu_op_e'(op);
  assign signed_op = ~op[0];
  assign sa        = signed_op & a[WIDTH-1];
  assign sb        = signed_op & b[WIDTH-1];
  assign a_mag     = sa ? -a : a;
  assign b_mag     = sb ? -b : b;
  assign load      = (state == IDLE) & start & ~op[2];
  assign step      = (state == CALC);

  mdu_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .is_div (is_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (acc)
  );

  // divide by zero forces an all-ones quotient regardless of signs
  assign prod    = neg_res ? -acc : acc;
  assign quo     = acc[WIDTH-1:0];
  assign rem     = acc[2*WIDTH-1:WIDTH];
  assign quo_fix = div_zero ? '1 : (neg_res ? -quo : quo);
  assign rem_fix = neg_rem ? -rem : rem;

  assign stall = (state == CALC)
               | ((state == FIXUP) & start & op[2]);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      op_e == MDU_MFHI: rdata = hi;
      op_e == MDU_MFLO: rdata = lo;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (op_e)
              MDU_MULT, MDU_MULTU,
              MDU_DIV, MDU_DIVU: begin
                state    <= CALC;
                cnt      <= CNTW'(WIDTH);
                is_div   <= op[1];
                neg_res  <= sa ^ sb;
                neg_rem  <= sa;
                div_zero <= (b == '0);
              end
              MDU_MTHI: hi <= a;
              MDU_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNTW'(1)) begin
            state <= FIXUP;
            done  <= 1'b1;
          end
        end
        FIXUP: begin
          state <= IDLE;
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: latency, stall,
// HI/LO results, MF/MT ops and mid-op reset.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  mdu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .rdata (rdata)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint sp;
    int     sq;
    int     sr;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return sp;
      end
      3'd1: return {32'b0, x} * {32'b0, y};
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return {32'h0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic pop_exp(output logic [63:0] e);
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
  endtask

  task automatic run_mdu(input string tag,
                         input logic [2:0] o,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [63:0] exp);
    int done_at = 0;
    int n_stall = 0;
    logic [63:0] e;
    sb_q.push_back(exp);
    issue(o, x, y);
    for (int i = 1; i <= 60 && done_at == 0; i++) begin
      @(negedge clk);
      if (done) begin
        done_at = i;
        check({tag, "_fixstall"}, stall, 0);
      end else if (stall) begin
        n_stall++;
      end
      if (done_at == 0) begin
        @(posedge clk); #1;
      end
    end
    check({tag, "_latency"}, done_at, 33);
    check({tag, "_stalls"}, n_stall, 32);
    @(posedge clk); #1;
    pop_exp(e);
    check({tag, "_hi"}, hi, e[63:32]);
    check({tag, "_lo"}, lo, e[31:0]);
    check({tag, "_done_off"}, done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int low_at;
    int done_at;
    int n_done;

    reset = 1'b1; start = 1'b0; op = 3'd0;
    a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b0;

    run_mdu("mult", 3'd0, 32'hFFFF_FFFF, 32'h2,
            {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_mdu("multu", 3'd1, 32'hFFFF_FFFF, 32'h2,
            {32'h0000_0001, 32'hFFFF_FFFE});
    run_mdu("div", 3'd2, 32'hFFFF_FFF9, 32'h2,
            {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_mdu("divu", 3'd3, 32'd100, 32'd7,
            {32'h0000_0002, 32'h0000_000E});
    run_mdu("divu0", 3'd3, 32'h1234_5678, 32'h0,
            {32'h1234_5678, 32'hFFFF_FFFF});
    run_mdu("div0n", 3'd2, 32'h8765_4321, 32'h0,
            {32'h8765_4321, 32'hFFFF_FFFF});
    run_mdu("divmin", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
            {32'h0, 32'h8000_0000});

    for (int k = 0; k < 6; k++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (k % 2 == 0) ? 32'($urandom_range(1, 300))
                        : $urandom;
      if (k == 3) ra = -ra;
      run_mdu("rand", ro, ra, rb, model(ro, ra, rb));
    end

    // MFHI arriving mid-multiply waits out FIXUP
    sb_q.push_back(model(3'd0, 32'd1234, 32'hFFFF_FFFB));
    issue(3'd0, 32'd1234, 32'hFFFF_FFFB);
    low_at = 0;
    done_at = 0;
    for (int i = 1; i <= 60 && low_at == 0; i++) begin
      if (i == 5) begin
        start = 1'b1; op = 3'd4;
      end
      @(negedge clk);
      if (done) done_at = i;
      if (!stall) low_at = i;
      if (low_at == 0) begin
        @(posedge clk); #1;
      end
    end
    pop_exp(e);
    check("mfhi_done", done_at, 33);
    check("mfhi_release", low_at, 34);
    check("mfhi_rdata", rdata, e[63:32]);
    op = 3'd5;
    #1;
    check("mflo_rdata", rdata, e[31:0]);
    start = 1'b0; op = 3'd0;

    // MTLO / MTHI while idle
    @(posedge clk); #1;
    start = 1'b1; op = 3'd7; a = 32'hCAFE_BABE;
    @(negedge clk);
    check("mtlo_stall", stall, 0);
    @(posedge clk); #1;
    check("mtlo_lo", lo, 32'hCAFE_BABE);
    check("mtlo_hi", hi, e[63:32]);
    op = 3'd6; a = 32'h0BAD_F00D;
    @(negedge clk);
    check("mthi_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    check("mthi_hi", hi, 32'h0BAD_F00D);

    // reset in the middle of a divide
    issue(3'd3, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_stall", stall, 1);
    reset = 1'b1;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_stall", stall, 0);
    check("arst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (stall) n_done++;
    end
    check("arst_no_done", n_done, 0);
    check("arst_hi_hold", hi, 0);
    check("arst_lo_hold", lo, 0);

    run_mdu("post_rst", 3'd0, 32'd7, 32'd6,
            {32'h0, 32'd42});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide unit with its controlling state machine, attached to the EX stage of the pipelined MIPS core.
- Executes MULT, MULTU, DIV and DIVU iteratively over WIDTH cycles and owns the HI/LO registers.
- Serves MFHI, MFLO, MTHI and MTLO.
- Drives a stall to the hazard logic while HI/LO are not yet valid.
- Signed operand handling reuses the core's sign-extension convention: two's complement, MSB is the sign.

Parameters:
- WIDTH, 32, operand, HI and LO width.
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  EX stage presents a valid MDU op this cycle.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- a  in  WIDTH  rs operand; also the MTHI/MTLO source.
- b  in  WIDTH  rt operand.
- stall  out  1  hold EX and earlier stages.
- done  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rdata  out  WIDTH  MFHI/MFLO result (combinational).

Behaviour:
Reset and outputs:
- Reset (async, any state) → state IDLE; hi, lo, counter and internal registers = 0; done = 0; stall = 0.
- Reset mid-CALC aborts the operation; no partial result reaches hi/lo.
- rdata = hi when op = MFHI, lo when op = MFLO, otherwise 0.
- rdata is valid only when stall = 0.

State IDLE:
- start with op 0-3: latch |a|, |b|, the result sign and the quotient/remainder sign (signed ops only); counter = WIDTH; go to CALC.
- start with op 6: hi <= a at the next edge. op 7: lo <= a at the next edge. No stall in either case.
- start with op 4/5: rdata served the same cycle. No stall.

State CALC:
- Multiply: shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
- Divide: restoring division, one quotient bit per cycle.
- Counter decrements every cycle; at counter = 1 go to FIXUP.

State FIXUP (1 cycle):
- Apply sign correction:
  - Product negated if operand signs differ.
  - Quotient negated if signs differ; remainder takes the sign of the dividend.
- Write hi/lo: mult → hi = upper word, lo = lower word; div → lo = quotient, hi = remainder.
- Assert done; return to IDLE.

Latency:
- start in cycle 0 → CALC in cycles 1..WIDTH → FIXUP in cycle WIDTH+1, with done high that cycle.
- hi/lo hold the new value from cycle WIDTH+2.

Stall:
- stall = 1 whenever state is CALC, or state is FIXUP and start is high with op 4-7.
- stall is combinational from state, start and op.
- start with op 0-3 while not IDLE is ignored. The issuer must not issue while stall = 1.

Divide by zero:
- Completes in normal latency with lo = all-ones and hi = a (unsigned view of the dividend); no trap.

Signed edge case:
- DIV of most-negative / -1 → lo = 0x80000000, hi = 0.

Decomposition:
- Shared package mdu_pkg:
  - op encodings (MDU_MULT..MDU_MTLO)
  - state encoding (IDLE, CALC, FIXUP)
  - WIDTH default.
- Natural sub-module mdu_iter_core:
  - Holds the accumulator/remainder register and one-step add/subtract-shift logic.
  - Controlled by load, step and is_div from the sequencer.
- The FSM, sign fixup and HI/LO registers stay in mdu_sequencer.

Test Plan:
- MULT a=0xFFFFFFFF, b=0x00000002 → done at cycle 33 after start; hi=0xFFFFFFFF, lo=0xFFFFFFFE; stall high in cycles 1..32.
- MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 → lo=0x0000000E, hi=0x00000002.
- DIVU by zero, a=0x12345678 → lo=0xFFFFFFFF, hi=0x12345678.
- MFHI issued at cycle 5 of a MULT → stall held until FIXUP ends, then rdata = new hi.
- MTLO a=0xCAFEBABE while idle → lo updated next edge, stall never high.
- Reset asserted at cycle 10 of a DIV → hi=lo=0 immediately, stall=0, done never pulses.
